// File: rtl/matmul_pkg.sv
// Shared types and width helpers for the NxN streaming matrix multiplier.
// Holds no logic. Every width is a constant function of N.
// It has no flow control of its own.
package matmul_pkg;

  // Top-level control states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD_A = 2'd1,
    ST_CALC   = 2'd2,
    ST_SEND   = 2'd3
  } state_t;

  // Width of a flat element index 0..N*N-1
  function automatic int idx_width(input int n);
    return (n * n > 1) ? $clog2(n * n) : 1;
  endfunction

  // Width of a row/column/MAC-phase counter 0..N-1
  function automatic int rc_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/matmul_nxn_stream_if.sv
// AXI-Stream style channel used for both the matrix input and the result output.
// The interface is pure wiring and adds no latency.
// The master drives valid/data/last and the slave drives ready.
interface matmul_nxn_stream_if #(
  parameter int DW = 32
);
  logic          tvalid;
  logic          tready;
  logic [DW-1:0] tdata;
  logic          tlast;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/matmul_mac.sv
// Single multiply-accumulate: sum = acc + low W bits of (a*b), signed or unsigned.
// Purely combinational, with no latency.
// There is no flow control; the caller decides when to commit the sum.
module matmul_mac #(
  parameter int W = 32
) (
  input  logic         signed_mode,
  input  logic [W-1:0] acc,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum
);

  logic [2*W-1:0] a_ext;
  logic [2*W-1:0] b_ext;
  logic [W-1:0]   prod_lo;

  // Extend operands to full product width, multiply, keep the low half, accumulate with wrap
  always_comb begin
    a_ext   = signed_mode ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
    b_ext   = signed_mode ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
    prod_lo = W'(a_ext * b_ext);
    sum     = acc + prod_lo;
  end

endmodule

// File: rtl/matmul_nxn_stream.sv
// Streams in A (optional) and B row-major, computes C = A x B, and streams C out row-major.
// Each B beat is followed by N MAC cycles, and C is sent once the last B beat has been applied.
// ss.tready drops during MAC phases, in SEND and in IDLE; C beats hold while sm.tready is low.
module matmul_nxn_stream
  import matmul_pkg::*;
#(
  parameter int N           = 4,
  parameter int pDATA_WIDTH = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic ap_start,
  input  logic reuse_a,
  input  logic signed_mode,
  output logic ap_idle,
  output logic ap_done,
  output logic err_tlast,
  matmul_nxn_stream_if.slave  ss,
  matmul_nxn_stream_if.master sm
);

  localparam int NN    = N * N;
  localparam int IDX_W = idx_width(N);
  localparam int RC_W  = rc_width(N);
  localparam logic [RC_W-1:0]  LAST_RC  = RC_W'(N - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NN - 1);

  state_t state, state_nxt;

  logic [pDATA_WIDTH-1:0] a_mem [NN];
  logic [pDATA_WIDTH-1:0] c_acc [NN];
  logic [pDATA_WIDTH-1:0] b_reg;
  logic [pDATA_WIDTH-1:0] mac_sum;

  // row/col track the incoming element position; bk/bj hold the position of the B beat being applied
  logic [RC_W-1:0]  row, col;
  logic [RC_W-1:0]  bk, bj, mac_i;
  logic             mac_busy;
  logic [IDX_W-1:0] send_idx;
  logic             signed_q;

  logic             in_last, send_last, ss_hs, sm_hs;
  logic [IDX_W-1:0] in_idx, a_idx, c_idx;

  assign in_last   = (row == LAST_RC) && (col == LAST_RC);
  assign send_last = (send_idx == LAST_IDX);
  assign in_idx    = IDX_W'(row * N + col);
  assign a_idx     = IDX_W'(mac_i * N + bk);
  assign c_idx     = IDX_W'(mac_i * N + bj);
  assign ss_hs     = ss.tvalid & ss.tready;
  assign sm_hs     = sm.tvalid & sm.tready;
  assign ap_idle   = (state == ST_IDLE);

  matmul_mac #(.W(pDATA_WIDTH)) u_mac (
    .signed_mode (signed_q),
    .acc         (c_acc[c_idx]),
    .a           (a_mem[a_idx]),
    .b           (b_reg),
    .sum         (mac_sum)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode and stream handshake outputs
  always_comb begin
    state_nxt = state;
    ss.tready = 1'b0;
    sm.tvalid = 1'b0;
    sm.tdata  = '0;
    sm.tlast  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ap_start) state_nxt = reuse_a ? ST_CALC : ST_LOAD_A;
      end
      ST_LOAD_A: begin
        ss.tready = 1'b1;
        if (ss.tvalid && in_last) state_nxt = ST_CALC;
      end
      ST_CALC: begin
        ss.tready = ~mac_busy;
        if (mac_busy && (mac_i == LAST_RC) && (bk == LAST_RC) && (bj == LAST_RC))
          state_nxt = ST_SEND;
      end
      ST_SEND: begin
        sm.tvalid = 1'b1;
        sm.tdata  = c_acc[send_idx];
        sm.tlast  = send_last;
        if (sm.tready && send_last) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: A store, B capture, MAC sequencing, output index, status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NN; i++) begin
        a_mem[i] <= '0;
        c_acc[i] <= '0;
      end
      b_reg     <= '0;
      row       <= '0;
      col       <= '0;
      bk        <= '0;
      bj        <= '0;
      mac_i     <= '0;
      mac_busy  <= 1'b0;
      send_idx  <= '0;
      signed_q  <= 1'b0;
      err_tlast <= 1'b0;
      ap_done   <= 1'b0;
    end else begin
      ap_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (ap_start) begin
            for (int i = 0; i < NN; i++) c_acc[i] <= '0;
            err_tlast <= 1'b0;
            signed_q  <= signed_mode;
            row       <= '0;
            col       <= '0;
            send_idx  <= '0;
            mac_busy  <= 1'b0;
          end
        end
        ST_LOAD_A, ST_CALC: begin
          if (ss_hs) begin
            if (state == ST_LOAD_A) begin
              a_mem[in_idx] <= ss.tdata;
            end else begin
              b_reg    <= ss.tdata;
              bk       <= row;
              bj       <= col;
              mac_i    <= '0;
              mac_busy <= 1'b1;
            end
            // tlast only flags framing errors; counting never resynchronises on it
            if (ss.tlast != in_last) err_tlast <= 1'b1;
            if (col == LAST_RC) begin
              col <= '0;
              row <= (row == LAST_RC) ? '0 : row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
          end else if (mac_busy) begin
            c_acc[c_idx] <= mac_sum;
            if (mac_i == LAST_RC) mac_busy <= 1'b0;
            else                  mac_i    <= mac_i + 1'b1;
          end
        end
        ST_SEND: begin
          if (sm_hs) begin
            if (send_last) begin
              send_idx <= '0;
              ap_done  <= 1'b1;
            end else begin
              send_idx <= send_idx + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_nxn_stream.sv
// Directed, table-driven bench for matmul_nxn_stream at N=4, 32-bit data.
// Each table row holds one operation's inputs and hand-computed C.
// Mid-run reset and an ignored ap_start are exercised by short hand-written sequences.
module tb_matmul_nxn_stream;

  logic clk;
  logic rst;
  logic ap_start, reuse_a, signed_mode;
  logic ap_idle, ap_done, err_tlast;

  matmul_nxn_stream_if #(.DW(32)) ss_if ();
  matmul_nxn_stream_if #(.DW(32)) sm_if ();

  matmul_nxn_stream #(.N(4), .pDATA_WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .ap_start    (ap_start),
    .reuse_a     (reuse_a),
    .signed_mode (signed_mode),
    .ap_idle     (ap_idle),
    .ap_done     (ap_done),
    .err_tlast   (err_tlast),
    .ss          (ss_if),
    .sm          (sm_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit                reuse;
    bit                sgn;
    bit                bp;       // random sm_tready
    int                tl_bad;   // A beat carrying a spurious tlast, -1 for none
    bit                err;      // expected err_tlast after the run
    logic [15:0][31:0] a;
    logic [15:0][31:0] b;
    logic [15:0][31:0] c;
  } vec_t;

  localparam int NVEC = 8;
  vec_t vecs [NVEC];

  int n_vec = 0;
  int n_err = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic send_beat(input logic [31:0] d, input logic l);
    int cyc = 0;
    ss_if.tvalid = 1'b1;
    ss_if.tdata  = d;
    ss_if.tlast  = l;
    while (ss_if.tready !== 1'b1 && cyc < 200) begin
      step();
      cyc++;
    end
    if (cyc >= 200) begin
      n_vec++;
      n_err++;
      $display("FAIL ss_accept: tready low for %0d cycles, expected 1", cyc);
    end
    step();
    ss_if.tvalid = 1'b0;
    ss_if.tlast  = 1'b0;
  endtask

  task automatic collect(input int v);
    int          idx = 0;
    int          cyc = 0;
    bit          prev_stall = 0;
    logic [31:0] prev_dat = '0;
    logic        prev_last = 1'b0;
    int          n_rdy17 = 0;
    while (idx < 16 && cyc < 2000) begin
      sm_if.tready = vecs[v].bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (vecs[v].reuse && ss_if.tready) n_rdy17++;
      if (sm_if.tvalid) begin
        if (prev_stall) begin
          chk($sformatf("v%0d_stall_dat%0d", v, idx), sm_if.tdata, prev_dat);
          chk($sformatf("v%0d_stall_last%0d", v, idx), 32'(sm_if.tlast), 32'(prev_last));
        end
        if (sm_if.tready) begin
          chk($sformatf("v%0d_c%0d", v, idx), sm_if.tdata, vecs[v].c[idx]);
          chk($sformatf("v%0d_tlast%0d", v, idx), 32'(sm_if.tlast), (idx == 15) ? 32'd1 : 32'd0);
          idx++;
        end
        prev_stall = !sm_if.tready;
        prev_dat   = sm_if.tdata;
        prev_last  = sm_if.tlast;
      end
      step();
      cyc++;
    end
    if (idx < 16) begin
      n_vec++;
      n_err++;
      $display("FAIL v%0d_beats: got %0d C beats, expected 16", v, idx);
    end
    sm_if.tready = 1'b0;
    chk($sformatf("v%0d_done", v), 32'(ap_done), 32'd1);
    chk($sformatf("v%0d_idle", v), 32'(ap_idle), 32'd1);
    chk($sformatf("v%0d_vld_off", v), 32'(sm_if.tvalid), 32'd0);
    step();
    chk($sformatf("v%0d_done_pulse", v), 32'(ap_done), 32'd0);
    if (vecs[v].reuse) begin
      chk($sformatf("v%0d_no_17th_beat", v), 32'(n_rdy17), 32'd0);
      ss_if.tvalid = 1'b0;
    end
  endtask

  task automatic run(input int v);
    reuse_a     = vecs[v].reuse;
    signed_mode = vecs[v].sgn;
    ap_start    = 1'b1;
    step();
    ap_start    = 1'b0;
    reuse_a     = 1'b0;
    signed_mode = 1'b0;
    chk($sformatf("v%0d_err_clr", v), 32'(err_tlast), 32'd0);
    chk($sformatf("v%0d_busy", v), 32'(ap_idle), 32'd0);
    if (!vecs[v].reuse) begin
      for (int i = 0; i < 16; i++) begin
        if (v == 0 && i == 3) begin
          // start pulse mid-load must be ignored
          ap_start = 1'b1;
          reuse_a  = 1'b1;
          step();
          ap_start = 1'b0;
          reuse_a  = 1'b0;
        end
        send_beat(vecs[v].a[i], (i == 15) || (i == vecs[v].tl_bad));
      end
    end
    for (int i = 0; i < 16; i++) send_beat(vecs[v].b[i], i == 15);
    if (vecs[v].reuse) begin
      ss_if.tvalid = 1'b1;
      ss_if.tdata  = 32'hDEAD_BEEF;
    end
    collect(v);
    chk($sformatf("v%0d_err_tlast", v), 32'(err_tlast), 32'(vecs[v].err));
  endtask

  task automatic mid_calc_reset();
    ap_start = 1'b1;
    step();
    ap_start = 1'b0;
    for (int i = 0; i < 16; i++) send_beat((i % 5 == 0) ? 32'd1 : 32'd0, i == 15);
    for (int i = 0; i < 5; i++) send_beat(32'(i + 1), 1'b0);
    step();
    rst = 1'b1;
    step();
    chk("midrst_idle", 32'(ap_idle), 32'd1);
    chk("midrst_sm_vld", 32'(sm_if.tvalid), 32'd0);
    chk("midrst_ss_rdy", 32'(ss_if.tready), 32'd0);
    chk("midrst_done", 32'(ap_done), 32'd0);
    rst = 1'b0;
    step();
  endtask

  logic [31:0] colneg [4];
  logic [31:0] rowsum [4];

  initial begin
    colneg = '{32'hFFFF_FFE4, 32'hFFFF_FFE0, 32'hFFFF_FFDC, 32'hFFFF_FFD8};
    rowsum = '{32'd10, 32'd26, 32'd42, 32'd58};
    for (int v = 0; v < NVEC; v++) begin
      vecs[v].reuse  = 0;
      vecs[v].sgn    = 0;
      vecs[v].bp     = 0;
      vecs[v].tl_bad = -1;
      vecs[v].err    = 0;
    end
    for (int i = 0; i < 16; i++) begin
      // v0: identity x 1..16
      vecs[0].a[i] = (i % 5 == 0) ? 32'd1 : 32'd0;
      vecs[0].b[i] = 32'(i + 1);
      vecs[0].c[i] = 32'(i + 1);
      // v1: signed -1 x 2
      vecs[1].a[i] = 32'hFFFF_FFFF;
      vecs[1].b[i] = 32'd2;
      vecs[1].c[i] = 32'hFFFF_FFF8;
      // v2: same data unsigned, wraps to the same low word
      vecs[2].a[i] = 32'hFFFF_FFFF;
      vecs[2].b[i] = 32'd2;
      vecs[2].c[i] = 32'hFFFF_FFF8;
      // v3: reuse stored all -1 A, B = 1..16 -> negated column sums
      vecs[3].a[i] = '0;
      vecs[3].b[i] = 32'(i + 1);
      vecs[3].c[i] = colneg[i % 4];
      // v4: 2*identity with spurious tlast on A beat 7
      vecs[4].a[i] = (i % 5 == 0) ? 32'd2 : 32'd0;
      vecs[4].b[i] = 32'(i + 1);
      vecs[4].c[i] = 32'(2 * (i + 1));
      // v5: A = 1..16, B all ones -> row sums
      vecs[5].a[i] = 32'(i + 1);
      vecs[5].b[i] = 32'd1;
      vecs[5].c[i] = rowsum[i / 4];
      // v6: reuse after reset, stored A cleared -> zero
      vecs[6].a[i] = '0;
      vecs[6].b[i] = 32'(i + 1);
      vecs[6].c[i] = '0;
      // v7: fresh identity run after reset
      vecs[7].a[i] = (i % 5 == 0) ? 32'd1 : 32'd0;
      vecs[7].b[i] = 32'(i + 1);
      vecs[7].c[i] = 32'(i + 1);
    end
    vecs[1].sgn    = 1;
    vecs[3].reuse  = 1;
    vecs[3].bp     = 1;
    vecs[4].tl_bad = 7;
    vecs[4].err    = 1;
    vecs[5].bp     = 1;
    vecs[6].reuse  = 1;

    rst          = 1'b1;
    ap_start     = 1'b0;
    reuse_a      = 1'b0;
    signed_mode  = 1'b0;
    ss_if.tvalid = 1'b0;
    ss_if.tdata  = '0;
    ss_if.tlast  = 1'b0;
    sm_if.tready = 1'b0;
    step();
    step();
    chk("rst_idle", 32'(ap_idle), 32'd1);
    chk("rst_done", 32'(ap_done), 32'd0);
    chk("rst_err", 32'(err_tlast), 32'd0);
    chk("rst_ss_rdy", 32'(ss_if.tready), 32'd0);
    chk("rst_sm_vld", 32'(sm_if.tvalid), 32'd0);
    chk("rst_sm_last", 32'(sm_if.tlast), 32'd0);
    chk("rst_sm_dat", sm_if.tdata, 32'd0);
    rst = 1'b0;
    step();

    for (int v = 0; v < NVEC; v++) begin
      if (v == 6) mid_calc_reset();
      run(v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
